ysyx_22041211_mem_arbiter: RTL
==============================

# ysyx_22041211_mem_arbiter

Two-requester memory arbiter for the NPC core. It shares one data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It arbitrates requests and registers the winning request. It drives the memory-side valid/ready handshake and routes the response back to the owner. Only one transaction is outstanding at a time; it sits between IFU/LSU and the data memory.

## Interface
- DATA_LEN, 32, data width
- ADDR_LEN, 32, address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_LEN  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_rdata  out  DATA_LEN  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_LEN  LSU address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_LEN  store data
- lsu_wmask  in  DATA_LEN/8  byte strobes
- lsu_resp_valid  out  1  load data / store ack valid
- lsu_rdata  out  DATA_LEN  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wdata  out  ADDR_LEN, DATA_LEN  registered request
- mem_wen  out  1  registered write enable
- mem_wmask  out  DATA_LEN/8  registered strobes; all-zero for IFU
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_LEN  memory read data

## Operation
- FSM states:
  - IDLE: accepts a new request.
  - REQ: mem_req_valid=1; waits for mem_req_ready.
  - WAIT: waits for mem_resp_valid.
- IDLE: if any req_valid, grant one. The winner's req_ready=1 combinationally. Capture addr/wen/wdata/wmask and the owner. Go to REQ.
- The non-winner's req_ready=0. It must hold valid and its payload stable until accepted.
- REQ: on mem_req_valid & mem_req_ready, go to WAIT. Payload outputs stay constant throughout REQ.
- WAIT: on mem_resp_valid, pulse owner's resp_valid for that cycle. Forward mem_rdata to the owner's rdata. Go to IDLE.
- Non-owner resp_valid=0 and rdata=0.
- IFU requests: mem_wen=0, mem_wmask=0, mem_wdata=0.
- LSU stores also receive resp_valid (ack). lsu_rdata then carries mem_rdata unmodified; the LSU ignores it.
- mem_resp_valid in IDLE or REQ: ignored, no state change.
- Requesters never backpressure responses.
- Tie (both valid in IDLE): resolved per Configuration.
- Reset asserted mid-transaction: FSM returns to IDLE and the transaction is dropped. Memory-side reset is the memory's responsibility.

## Timing
- Reset values:
  - state=IDLE, owner=IFU, last_grant=IFU.
  - mem_req_valid=0; mem_addr/mem_wdata/mem_wmask/mem_wen=0.
  - All resp_valid=0, all rdata=0.
- req_ready is high only in IDLE, for at most one requester per cycle.
- Accept at cycle N → mem_req_valid=1 from cycle N+1.
- With mem_req_ready=1 at N+1 and mem_resp_valid at N+2: resp_valid at N+2, and a new grant is possible at N+3. Minimum 3 cycles per transaction.
- Memory must not assert mem_resp_valid in the same cycle as the request handshake.
- Response path is combinational: mem_resp_valid/mem_rdata → owner resp_valid/rdata, no added latency.

## Configuration
- YSYX_22041211_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the requester that did not receive the last grant.
  - last_grant updates on every grant.
  - The first tie after reset goes to LSU.
- Not defined: fixed priority, LSU always wins ties. last_grant is absent.
- A single requester is always granted immediately in both modes.

## Structure
- Package ysyx_22041211_pkg holds:
  - state enum {IDLE, REQ, WAIT}.
  - owner encoding (OWNER_IFU=0, OWNER_LSU=1).
  - Default width constants.
- One sub-module, ysyx_22041211_arb_pick: combinational grant selection from two valids plus last_grant, with the macro handled inside it.
- Remainder (FSM, request registers, response routing) lives in the top.

## Test plan
- IFU only, addr 0x80000000; mem ready immediately, responds next cycle with rdata 0x00000413 → ifu_resp_valid one cycle with 0x00000413; lsu_resp_valid stays 0.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF → mem_wen=1 and payload held stable across 3 cycles of mem_req_ready=0; lsu_resp_valid pulses on ack.
- Both valid every cycle, 4 transactions:
  - With RR_EN: grants alternate LSU, IFU, LSU, IFU.
  - Without RR_EN: all four grants go to LSU.
- mem_resp_valid=1 while in REQ, with mem_req_ready held 0 → no resp_valid, FSM stays in REQ.
- rst low during WAIT → next cycle all outputs at reset values. A subsequent IFU request is accepted in IDLE and a late mem_resp_valid from the dropped transaction is ignored.
- Back-to-back LSU loads with zero-wait memory → exactly one grant per 3 cycles; lsu_req_ready is low in REQ and WAIT.

Source files
------------

// File: rtl/ysyx_22041211_pkg.sv
// Shared types and default widths for the NPC memory arbiter.
// YSYX_22041211_ARB_RR_EN selects round-robin tie-breaking (see arb_pick).
package ysyx_22041211_pkg;

  localparam int DATA_LEN_DEF = 32;
  localparam int ADDR_LEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_22041211_arb_pick.sv
// Combinational grant selection between IFU and LSU.
// YSYX_22041211_ARB_RR_EN: round-robin on ties; otherwise LSU wins ties.
module ysyx_22041211_arb_pick
  import ysyx_22041211_pkg::*;
(
  input  logic   ifu_valid,
  input  logic   lsu_valid,
`ifdef YSYX_22041211_ARB_RR_EN
  input  owner_t last_grant,
`endif
  output logic   grant_valid,
  output owner_t grant
);

  always_comb begin
    grant_valid = ifu_valid | lsu_valid;
    grant       = OWNER_IFU;
    if (ifu_valid && lsu_valid) begin
`ifdef YSYX_22041211_ARB_RR_EN
      grant = (last_grant == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
`else
      grant = OWNER_LSU;
`endif
    end else if (lsu_valid) begin
      grant = OWNER_LSU;
    end
  end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight.
// YSYX_22041211_ARB_RR_EN enables round-robin tie-breaking via last_grant.
//
// state | meaning
// IDLE  | accepting a new request from IFU or LSU
// REQ   | mem_req_valid high, waiting for mem_req_ready
// WAIT  | request taken by memory, waiting for mem_resp_valid
module ysyx_22041211_mem_arbiter
  import ysyx_22041211_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_LEN-1:0]   ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_LEN-1:0]   ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_LEN-1:0]   lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_LEN-1:0]   lsu_wdata,
  input  logic [DATA_LEN/8-1:0] lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_LEN-1:0]   lsu_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_LEN-1:0]   mem_addr,
  output logic [DATA_LEN-1:0]   mem_wdata,
  output logic                  mem_wen,
  output logic [DATA_LEN/8-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_LEN-1:0]   mem_rdata
);

  state_t state, state_nxt;
  owner_t owner;
  owner_t grant;
  logic   grant_valid;
  logic   accept;

`ifdef YSYX_22041211_ARB_RR_EN
  owner_t last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_grant <= OWNER_IFU;
    else if (accept) last_grant <= grant;
  end
`endif

  ysyx_22041211_arb_pick u_pick (
    .ifu_valid   (ifu_req_valid),
    .lsu_valid   (lsu_req_valid),
`ifdef YSYX_22041211_ARB_RR_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign accept        = (state == IDLE) && grant_valid;
  assign mem_req_valid = (state == REQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid)    state_nxt = REQ;
      REQ:     if (mem_req_ready)  state_nxt = WAIT;
      WAIT:    if (mem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Payload is only loaded on accept, so it stays frozen through REQ and WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWNER_IFU;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wen   <= 1'b0;
      mem_wmask <= '0;
    end else if (accept) begin
      owner <= grant;
      if (grant == OWNER_LSU) begin
        mem_addr  <= lsu_addr;
        mem_wdata <= lsu_wdata;
        mem_wen   <= lsu_wen;
        mem_wmask <= lsu_wmask;
      end else begin
        mem_addr  <= ifu_addr;
        mem_wdata <= '0;
        mem_wen   <= 1'b0;
        mem_wmask <= '0;
      end
    end
  end

  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    if (accept) begin
      ifu_req_ready = (grant == OWNER_IFU);
      lsu_req_ready = (grant == OWNER_LSU);
    end
    if ((state == WAIT) && mem_resp_valid) begin
      if (owner == OWNER_LSU) begin
        lsu_resp_valid = 1'b1;
        lsu_rdata      = mem_rdata;
      end else begin
        ifu_resp_valid = 1'b1;
        ifu_rdata      = mem_rdata;
      end
    end
  end

endmodule
